// File: rtl/instr_register_ctrl.sv
// Instruction register front-end: round-robin write arbiter for two
// requesters plus an in-order read sequencer. With the register file it
// forms a 32-entry arbitrated FIFO.

package instr_register_pkg;

  localparam int unsigned OPCODE_W  = 4;
  localparam int unsigned OPERAND_W = 32;
  localparam int unsigned RESULT_W  = 64;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned COUNT_W   = ADDR_W + 1;

  typedef logic        [OPCODE_W-1:0]  opcode_t;
  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef logic signed [RESULT_W-1:0]  result_t;
  typedef logic        [ADDR_W-1:0]    address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  res;
  } instruction_t;

endpackage

module instr_register_ctrl
  import instr_register_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  // requester 0
  input  logic                req0_valid,
  output logic                req0_ready,
  input  opcode_t             req0_opcode,
  input  operand_t            req0_op_a,
  input  operand_t            req0_op_b,
  // requester 1
  input  logic                req1_valid,
  output logic                req1_ready,
  input  opcode_t             req1_opcode,
  input  operand_t            req1_op_a,
  input  operand_t            req1_op_b,
  // instruction register write port
  output logic                load_en,
  output opcode_t             opcode,
  output operand_t            operand_a,
  output operand_t            operand_b,
  output address_t            write_pointer,
  // instruction register read port
  output address_t            read_pointer,
  input  instruction_t        instruction_word,
  // consumer
  output logic                rd_valid,
  input  logic                rd_ready,
  output instruction_t        rd_word,
  // occupancy
  output logic [COUNT_W-1:0]  count,
  output logic                full,
  output logic                empty
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(DEPTH);

  // prio == 0 prefers req0, prio == 1 prefers req1
  logic               prio;
  logic               grant0;
  logic               grant1;
  logic               push;
  logic               both_valid;
  address_t           wr_ptr;

  logic [COUNT_W-1:0] avail;
  logic [COUNT_W-1:0] avail_next;
  logic [COUNT_W-1:0] count_next;

  logic [0:0]         state;
  logic [0:0]         state_next;
  logic               rd_valid_next;
  instruction_t       rd_word_next;
  address_t           rd_ptr_next;
  logic               pop;

  // Round-robin grant; a lone valid requester always wins
  always_comb begin
    grant0 = req0_valid & (~req1_valid | ~prio);
    grant1 = req1_valid & (~req0_valid |  prio);
  end

  assign req0_ready = grant0 & ~full & ~flush & ~reset;
  assign req1_ready = grant1 & ~full & ~flush & ~reset;

  assign push       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign both_valid = req0_valid & req1_valid;

  // Write port pipeline: one registered load_en cycle per accepted request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_en       <= 1'b0;
      opcode        <= '0;
      operand_a     <= '0;
      operand_b     <= '0;
      write_pointer <= '0;
      wr_ptr        <= '0;
      prio          <= 1'b0;
    end else if (flush) begin
      load_en <= 1'b0;
      wr_ptr  <= '0;
      prio    <= 1'b0;
    end else begin
      load_en <= push;
      if (push) begin
        if (req0_ready) begin
          opcode    <= req0_opcode;
          operand_a <= req0_op_a;
          operand_b <= req0_op_b;
        end else begin
          opcode    <= req1_opcode;
          operand_a <= req1_op_a;
          operand_b <= req1_op_b;
        end
        write_pointer <= wr_ptr;
        wr_ptr        <= wr_ptr + ADDR_W'(1);
        // contention served: hand preference to the other requester
        if (both_valid) begin
          prio <= ~prio;
        end
      end
    end
  end

  // Next occupancy: accepted-but-unpopped and committed-but-unpopped
  always_comb begin
    count_next = count + COUNT_W'(push) - COUNT_W'(pop);
    avail_next = avail + COUNT_W'(load_en) - COUNT_W'(pop);
    if (flush) begin
      count_next = '0;
      avail_next = '0;
    end
  end

  // Occupancy registers and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      avail <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= count_next;
      avail <= avail_next;
      full  <= (count_next == COUNT_FULL);
      empty <= (count_next == '0);
    end
  end

  // Read sequencer next-state: capture when a committed entry exists, hold until taken
  always_comb begin
    state_next    = state;
    rd_valid_next = rd_valid;
    rd_word_next  = rd_word;
    rd_ptr_next   = read_pointer;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (avail != '0) begin
          rd_word_next  = instruction_word;
          rd_valid_next = 1'b1;
          state_next    = HOLD;
        end
      end
      HOLD: begin
        if (rd_ready) begin
          rd_valid_next = 1'b0;
          rd_ptr_next   = read_pointer + ADDR_W'(1);
          pop           = 1'b1;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next    = IDLE;
        rd_valid_next = 1'b0;
      end
    endcase
    if (flush) begin
      state_next    = IDLE;
      rd_valid_next = 1'b0;
      rd_ptr_next   = '0;
      pop           = 1'b0;
    end
  end

  // Read sequencer state and registered read outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rd_valid     <= 1'b0;
      rd_word      <= '0;
      read_pointer <= '0;
    end else begin
      state        <= state_next;
      rd_valid     <= rd_valid_next;
      rd_word      <= rd_word_next;
      read_pointer <= rd_ptr_next;
    end
  end

endmodule

// File: doc/instr_register_ctrl.md
# instr_register_ctrl

Controller that sits in front of the instruction register and shares its write port between two requesters. Accepted instructions go into consecutive register locations, and a read sequencer returns them to a single consumer in acceptance order. Together with the register file it behaves as a 32-entry arbitrated FIFO. The block drives every control input of the instruction register; the testbench and requesters no longer drive the pointers directly.

## Interface
- DEPTH, 32, number of register locations; must equal 2**width(address_t).
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of pointers, counts and the read sequencer.
- req0_valid / req1_valid  in  1  requester N presents an instruction.
- req0_ready / req1_ready  out  1  requester N's instruction is accepted this cycle (combinational).
- req0_opcode / req1_opcode  in  opcode_t (4)  requested opcode.
- req0_op_a / req1_op_a, req0_op_b / req1_op_b  in  operand_t (32, signed)  requested operands.
- load_en  out  1  write strobe to the instruction register.
- opcode  out  opcode_t  write data to the instruction register.
- operand_a, operand_b  out  operand_t  write data to the instruction register.
- write_pointer  out  address_t (5)  write address.
- read_pointer  out  address_t (5)  read address; the instruction register read path is combinational.
- instruction_word  in  instruction_t  read data (opc, op_a, op_b, res) from the instruction register.
- rd_valid  out  1  rd_word holds the oldest unread instruction.
- rd_ready  in  1  consumer accepts rd_word.
- rd_word  out  instruction_t  registered copy of instruction_word.
- count  out  6  entries accepted but not yet popped, range 0..32.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
**Arbitration (write side)**
- Round-robin between the two requesters. A priority bit names the preferred requester; after reset and after flush it prefers req0.
- Grant rule:
  - Only one requester valid: that requester is granted.
  - Both valid: the preferred requester is granted, and the priority bit then points at the other requester.
- reqN_ready = grantN & ~full & ~flush & ~reset. A transfer occurs when reqN_valid & reqN_ready is high at a posedge.
- On a transfer:
  - The next cycle drives load_en=1, opcode/operand_a/operand_b from the granted request, and write_pointer=wr_ptr.
  - wr_ptr increments modulo DEPTH.
  - count increments.
- With no transfer, load_en=0 and the data/pointer outputs hold their previous values.
- avail, an internal count of committed unread entries, increments on the posedge at which load_en=1. Entries are therefore readable only after the register file has written them.

**Read sequencer (two-state FSM)**
- read_pointer = rd_ptr at all times.
- IDLE:
  - If avail>0: capture instruction_word into rd_word, set rd_valid=1, go to HOLD.
  - Otherwise remain in IDLE.
- HOLD:
  - rd_word is held stable.
  - On rd_ready: clear rd_valid, increment rd_ptr modulo DEPTH, decrement count and avail, return to IDLE.
- Accept and pop on the same edge: count is unchanged.
- The res field passes through unchanged; the controller never drives it.

**Flush** (priority over accept and pop)
- On the next posedge: wr_ptr, rd_ptr, count and avail become 0, load_en=0, rd_valid=0, FSM goes to IDLE, priority bit resets to req0.
- A write whose load_en cycle coincides with flush still lands in the register file but is not counted.

## Timing
- Reset values:
  - load_en=0, opcode=0, operand_a=0, operand_b=0.
  - write_pointer=0, read_pointer=0.
  - req0_ready=req1_ready=0 while reset is high.
  - rd_valid=0, rd_word=0, count=0, empty=1, full=0.
  - FSM in IDLE.
- Reset asserted at any point, including mid-HOLD or in a load_en cycle, takes effect immediately and discards all in-flight state.
- Write path, with the transfer at edge T:
  - load_en is high between T and T+1.
  - The register file writes at T+1.
  - rd_valid rises at T+2 at the earliest.
- Read throughput: one pop per two cycles (IDLE→HOLD→IDLE).
- Full: both readies are 0. A pop at edge T frees a slot, and ready can rise in the cycle after T.
- Wrap-around: pointers roll 31→0 without any gap in acceptance.
- Requesters must not make valid depend on ready.

## Test plan
- Reset check: hold reset for 2 cycles → every output equals its reset value. Then req0 writes opcode=3, op_a=5, op_b=9 → load_en high exactly 1 cycle with write_pointer=0. rd_valid rises 2 cycles after accept with rd_word opc=3, op_a=5, op_b=9.
- Fairness: req0 and req1 both held valid for 6 cycles → grants alternate 0,1,0,1,0,1 and write_pointer steps 0..5. Readback order matches the grant order.
- Full and recovery: 32 accepts with rd_ready=0 → full=1, count=32, both readies 0. One pop → full=0 and one more accept is taken with write_pointer=0.
- Wrap-around: 40 transactions with rd_ready=1 → all 40 read back in order with correct data. The pointers wrap 31→0 and count never exceeds 32.
- Simultaneous accept and pop, with count=5 → count stays 5 and empty/full are unchanged.
- Disruption mid-operation:
  - Flush while in HOLD with count=4 → next cycle count=0, rd_valid=0, empty=1.
  - Async reset between clock edges → outputs return to reset values before the next posedge.
